// File: rtl/mega_jsoc_sysid_checker.sv
// Reads the ID and timestamp words from a sysid slave over Avalon-MM and
// compares them. Optional retry behaviour: define SYSID_CHECK_RETRY_EN.
module mega_jsoc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd29,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1718298719,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    typedef enum logic [2:0] {
        StIdle, StRdId, StWtId, StRdTs, StWtTs, StCmp, StDone
    } state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        id_ok_q, id_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic        expired;
    logic        fail;
    logic        can_retry;

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] attempt_q, attempt_d;
    assign can_retry = (attempt_q != 2'd2);
`else
    assign can_retry = 1'b0;
`endif

    // The cycle whose end brings the counter to TIMEOUT_CYCLES; progress wins over expiry.
    assign expired = (cnt_q >= TimeoutLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_ok_d   = id_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        fail      = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        attempt_d = attempt_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StRdId;
                cnt_d   = 16'd0;
            end
            StRdId, StRdTs: begin
                cnt_d = cnt_q + 16'd1;
                if (!avm_waitrequest) begin
                    state_d = (state_q == StRdId) ? StWtId : StWtTs;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StWtId: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    cap_id_d = avm_readdata;
                    state_d  = StRdTs;
                    cnt_d    = 16'd0;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StWtTs: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    cap_ts_d = avm_readdata;
                    state_d  = StCmp;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            StCmp: begin
                if (cap_id_q == EXPECTED_ID && cap_ts_q == EXPECTED_TIMESTAMP) begin
                    id_ok_d = 1'b1;
                    state_d = StDone;
                end else if (can_retry) begin
                    state_d = StRdId;
                    cnt_d   = 16'd0;
`ifdef SYSID_CHECK_RETRY_EN
                    attempt_d = attempt_q + 2'd1;
`endif
                end else begin
                    id_ok_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    id_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = StRdId;
`ifdef SYSID_CHECK_RETRY_EN
                    attempt_d = 2'd0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (fail) begin
            cnt_d = 16'd0;
            if (can_retry) begin
                state_d = StRdId;
`ifdef SYSID_CHECK_RETRY_EN
                attempt_d = attempt_q + 2'd1;
`endif
            end else begin
                timeout_d = 1'b1;
                id_ok_d   = 1'b0;
                state_d   = StDone;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            id_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= 32'd0;
            cap_ts_q  <= 32'd0;
`ifdef SYSID_CHECK_RETRY_EN
            attempt_q <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_ok_q   <= id_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
`ifdef SYSID_CHECK_RETRY_EN
            attempt_q <= attempt_d;
`endif
        end
    end

    assign avm_read    = (state_q == StRdId) || (state_q == StRdTs);
    assign avm_address = (state_q == StRdTs);
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign done        = (state_q == StDone);
    assign id_ok       = id_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_mega_jsoc_sysid_checker.sv
// Directed bench for mega_jsoc_sysid_checker with a behavioural sysid slave
// (configurable stall, fixed one-cycle read latency).
module tb_mega_jsoc_sysid_checker;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        timeout;
    logic [31:0] captured_id;
    logic [31:0] captured_ts;

    localparam logic [31:0] ExpId = 32'd29;
    localparam logic [31:0] ExpTs = 32'd1718298719;

    int n_checks = 0;
    int n_bad    = 0;

    // Slave model controls
    int          stall_cfg   = 0;
    int          stall_left  = 0;
    logic [31:0] slv_id      = ExpId;
    logic [31:0] slv_ts      = ExpTs;
    logic        force_valid = 1'b0;
    logic        pend        = 1'b0;
    logic        pend_addr   = 1'b0;
    int          id_reads    = 0;

    mega_jsoc_sysid_checker dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .timeout           (timeout),
        .captured_id       (captured_id),
        .captured_ts       (captured_ts)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slave responds on the falling edge so inputs are stable at the rising edge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clock);
            avm_readdatavalid = pend | force_valid;
            avm_readdata = pend ? (pend_addr ? slv_ts : slv_id)
                                : (force_valid ? 32'hdead_beef : 32'd0);
            pend = 1'b0;
            if (avm_read) begin
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    pend      = 1'b1;
                    pend_addr = avm_address;
                    if (!avm_address) id_reads++;
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_left      = stall_cfg;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("done_wait", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n_rd;
        reset_n = 1'b0;
        start   = 1'b0;

        // Reset state
        tick(2);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_id_ok", {31'd0, id_ok}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_read", {31'd0, avm_read}, 32'd0);
        check_eq("rst_addr", {31'd0, avm_address}, 32'd0);
        check_eq("rst_cap_id", captured_id, 32'd0);
        check_eq("rst_cap_ts", captured_ts, 32'd0);

        // Nominal: done six cycles after reset release
        reset_n = 1'b1;
        tick(1);
        check_eq("nom_busy", {31'd0, busy}, 32'd1);
        check_eq("nom_read", {31'd0, avm_read}, 32'd1);
        check_eq("nom_addr", {31'd0, avm_address}, 32'd0);
        tick(4);
        check_eq("nom_done_early", {31'd0, done}, 32'd0);
        tick(1);
        check_eq("nom_done", {31'd0, done}, 32'd1);
        check_eq("nom_id_ok", {31'd0, id_ok}, 32'd1);
        check_eq("nom_timeout", {31'd0, timeout}, 32'd0);
        check_eq("nom_busy_end", {31'd0, busy}, 32'd0);
        check_eq("nom_cap_id", captured_id, ExpId);
        check_eq("nom_cap_ts", captured_ts, ExpTs);

        // Start in DONE restarts; start while busy is ignored
        pulse_start();
        check_eq("st_done_drop", {31'd0, done}, 32'd0);
        check_eq("st_id_ok_clr", {31'd0, id_ok}, 32'd0);
        check_eq("st_read", {31'd0, avm_read}, 32'd1);
        check_eq("st_addr", {31'd0, avm_address}, 32'd0);
        tick(1);
        pulse_start();
        check_eq("busy_start_addr", {31'd0, avm_address}, 32'd1);
        check_eq("busy_start_read", {31'd0, avm_read}, 32'd1);
        tick(3);
        check_eq("busy_start_done", {31'd0, done}, 32'd1);
        check_eq("busy_start_ok", {31'd0, id_ok}, 32'd1);

        // Four stall cycles per read
        stall_cfg = 4;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_read", {31'd0, avm_read}, 32'd1);
            check_eq("stall_addr", {31'd0, avm_address}, 32'd0);
            tick(1);
        end
        wait_done(100);
        check_eq("stall_id_ok", {31'd0, id_ok}, 32'd1);
        check_eq("stall_timeout", {31'd0, timeout}, 32'd0);

        // Boundary: data arrives on the timeout cycle and wins
        stall_cfg = 254;
        pulse_start();
        wait_done(2000);
        check_eq("edge_id_ok", {31'd0, id_ok}, 32'd1);
        check_eq("edge_timeout", {31'd0, timeout}, 32'd0);

        // Timeout with a stalled slave
`ifdef SYSID_CHECK_RETRY_EN
        stall_cfg = 1000;
`else
        stall_cfg = 300;
`endif
        pulse_start();
        n_rd = 0;
        while (!done && n_rd < 2000) begin
            if (avm_read) n_rd++;
            tick(1);
        end
`ifdef SYSID_CHECK_RETRY_EN
        check_eq("to_read_cycles", n_rd, 32'd765);
`else
        check_eq("to_read_cycles", n_rd, 32'd255);
`endif
        check_eq("to_done", {31'd0, done}, 32'd1);
        check_eq("to_flag", {31'd0, timeout}, 32'd1);
        check_eq("to_id_ok", {31'd0, id_ok}, 32'd0);
        check_eq("to_read_low", {31'd0, avm_read}, 32'd0);
        stall_cfg = 0;
        tick(2);

        // Wrong ID word
        slv_id   = 32'd30;
        id_reads = 0;
        pulse_start();
        wait_done(100);
        check_eq("bad_id_ok", {31'd0, id_ok}, 32'd0);
        check_eq("bad_timeout", {31'd0, timeout}, 32'd0);
        check_eq("bad_cap_id", captured_id, 32'd30);
`ifdef SYSID_CHECK_RETRY_EN
        check_eq("bad_id_reads", id_reads, 32'd3);
`else
        check_eq("bad_id_reads", id_reads, 32'd1);
`endif
        slv_id = ExpId;

        // Reset while waiting for the timestamp, then stray valids
        pulse_start();
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_done", {31'd0, done}, 32'd0);
        check_eq("mid_id_ok", {31'd0, id_ok}, 32'd0);
        check_eq("mid_read", {31'd0, avm_read}, 32'd0);
        check_eq("mid_cap_id", captured_id, 32'd0);
        check_eq("mid_cap_ts", captured_ts, 32'd0);
        reset_n     = 1'b1;
        force_valid = 1'b1;
        tick(2);
        force_valid = 1'b0;
        check_eq("stray_ignored", captured_id, 32'd0);
        wait_done(100);
        check_eq("mid_rerun_ok", {31'd0, id_ok}, 32'd1);
        check_eq("mid_rerun_id", captured_id, ExpId);
        check_eq("mid_rerun_ts", captured_ts, ExpTs);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
